gmux_sel_ctrl: RTL and testbench

Sequential controller that drives the select input of a two-input clock multiplexer (GMUX) and the enable of the downstream clock gate. It accepts switch requests over a valid/ready handshake. It sequences gate-off, select change, settle and gate-on so the muxed clock never sees a runt pulse. It sits in the fabric clock-control region, clocked by a free-running reference clock, with `sel` wired to the GMUX select (`IS0`) and `gate_en` wired to the gate after the GMUX output.

---
 rtl/gmux_sel_ctrl_pkg.sv | 23 ++
 rtl/gmux_sel_ctrl_if.sv | 26 ++
 rtl/gmux_dly_cnt.sv | 33 +++
 rtl/gmux_sel_ctrl.sv | 142 ++++++++++++++
 tb/tb_gmux_sel_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/gmux_sel_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmux_sel_ctrl_pkg                                                  |
// | Shared types and sizing helpers for the GMUX select controller.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package gmux_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2
  } state_t;

  // Wide enough to hold the larger of the two reload values.
  function automatic int cnt_width(input int off_c, input int settle_c);
    int m;
    m = (off_c > settle_c) ? off_c : settle_c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gmux_sel_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmux_sel_ctrl_if                                                   |
// | Request handshake and clock-control outputs of the GMUX controller.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface gmux_sel_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic sel;
  logic gate_en;
  logic busy;
  logic done;

  modport master (
    output req_valid, req_sel,
    input  req_ready, sel, gate_en, busy, done
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, sel, gate_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/gmux_dly_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmux_dly_cnt                                                       |
// | Loadable down-counter with enable and zero flag; holds at zero.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gmux_dly_cnt #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic                  zero
);

  logic [WIDTH-1:0] r_cnt;

  assign zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && !zero) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmux_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmux_sel_ctrl                                                      |
// | Sequences gate-off, GMUX select change, settle and gate-on.        |
// | Optional macro GMUX_SEL_CTRL_LOCK_EN adds a lock input that holds  |
// | off new requests while idle.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gmux_sel_ctrl
  import gmux_sel_ctrl_pkg::*;
#(
  parameter int   OFF_CYCLES    = 4,
  parameter int   SETTLE_CYCLES = 2,
  parameter logic INIT_SEL      = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
`ifdef GMUX_SEL_CTRL_LOCK_EN
  input  wire logic          lock,
`endif
  gmux_sel_ctrl_if.slave     bus
);

  localparam int                 c_CNT_W     = cnt_width(OFF_CYCLES, SETTLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_OFF_LD    = c_CNT_W'(OFF_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE_CYCLES - 1);

  state_t r_state, w_nxt_state;
  logic   r_sel, w_nxt_sel;
  logic   r_gate_en, w_nxt_gate_en;
  logic   r_done, w_nxt_done;
  logic   r_busy, w_nxt_busy;
  logic   r_target, w_nxt_target;
  logic   r_same_pend, w_nxt_same_pend;

  logic               w_ready;
  logic               w_accept;
  logic               w_cnt_load;
  logic               w_cnt_en;
  logic               w_cnt_zero;
  logic [c_CNT_W-1:0] w_cnt_ld_val;

`ifdef GMUX_SEL_CTRL_LOCK_EN
  assign w_ready = (r_state == IDLE) && !lock;
`else
  assign w_ready = (r_state == IDLE);
`endif
  assign w_accept = bus.req_valid && w_ready;

  assign bus.req_ready = w_ready;
  assign bus.sel       = r_sel;
  assign bus.gate_en   = r_gate_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  gmux_dly_cnt #(
    .WIDTH    (c_CNT_W)
  ) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_ld_val),
    .en       (w_cnt_en),
    .zero     (w_cnt_zero)
  );

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_sel       = r_sel;
    w_nxt_gate_en   = r_gate_en;
    w_nxt_target    = r_target;
    // A same-select request completes one edge after acceptance.
    w_nxt_done      = r_same_pend;
    w_nxt_same_pend = 1'b0;
    w_cnt_load      = 1'b0;
    w_cnt_en        = 1'b0;
    w_cnt_ld_val    = c_OFF_LD;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_sel != r_sel) begin
            w_nxt_target  = bus.req_sel;
            w_nxt_gate_en = 1'b0;
            w_cnt_load    = 1'b1;
            w_cnt_ld_val  = c_OFF_LD;
            w_nxt_state   = GATE_OFF;
          end else begin
            w_nxt_same_pend = 1'b1;
          end
        end
      end
      GATE_OFF: begin
        if (w_cnt_zero) begin
          w_nxt_sel    = r_target;
          w_cnt_load   = 1'b1;
          w_cnt_ld_val = c_SETTLE_LD;
          w_nxt_state  = SWITCH;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      SWITCH: begin
        if (w_cnt_zero) begin
          w_nxt_gate_en = 1'b1;
          w_nxt_done    = 1'b1;
          w_nxt_state   = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_nxt_state   = IDLE;
        w_nxt_gate_en = 1'b1;
      end
    endcase

    w_nxt_busy = (w_nxt_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= INIT_SEL;
      r_gate_en   <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_target    <= INIT_SEL;
      r_same_pend <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_sel       <= w_nxt_sel;
      r_gate_en   <= w_nxt_gate_en;
      r_done      <= w_nxt_done;
      r_busy      <= w_nxt_busy;
      r_target    <= w_nxt_target;
      r_same_pend <= w_nxt_same_pend;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmux_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gmux_sel_ctrl                                                   |
// | Scoreboard bench: randomized switch requests vs. a timeline model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_gmux_sel_ctrl;

  localparam int   OFF  = 4;
  localparam int   SET  = 2;
  localparam logic INIT = 1'b0;

  typedef struct {
    int   done_edge;
    int   chg_edge;
    int   low;
    logic sel;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmux_sel_ctrl_if bus ();
`ifdef GMUX_SEL_CTRL_LOCK_EN
  logic lock = 1'b0;
`endif

  gmux_sel_ctrl #(
    .OFF_CYCLES    (OFF),
    .SETTLE_CYCLES (SET),
    .INIT_SEL      (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef GMUX_SEL_CTRL_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus)
  );

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;
  int   model_free = 0;
  logic model_sel = INIT;
  int   low_cnt = 0;
  int   last_chg = -1;
  logic prev_sel = INIT;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic logic lock_now();
`ifdef GMUX_SEL_CTRL_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  // One cycle of stimulus; predicts acceptance on the upcoming edge.
  task automatic drive_cycle(input logic v, input logic s, output logic acc);
    logic exp_ready;
    exp_t rec;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_sel   = s;
    exp_ready = (edge_n >= model_free) && !lock_now();
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", bus.busy, edge_n < model_free);
    acc = v && exp_ready;
    if (acc) begin
      rec.sel = s;
      if (s != model_sel) begin
        rec.done_edge = edge_n + OFF + SET;
        rec.chg_edge  = edge_n + OFF;
        rec.low       = OFF + SET;
        model_free    = edge_n + OFF + SET + 1;
        model_sel     = s;
      end else begin
        rec.done_edge = edge_n + 1;
        rec.chg_edge  = -1;
        rec.low       = 0;
        model_free    = edge_n + 1;
      end
      sbq.push_back(rec);
    end
  endtask

  task automatic send(input logic s);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      drive_cycle(1'b1, s, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got not-accepted expected accepted (sel %0d)", s);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, acc);
  endtask

  // Monitor: pops the scoreboard whenever done pulses.
  initial begin
    exp_t rec;
    int   le;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      le = edge_n - 1;
      if (bus.sel !== prev_sel) last_chg = le;
      prev_sel = bus.sel;
      if (bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (edge %0d)", le);
        end else begin
          rec = sbq.pop_front();
          check("done_edge", le, rec.done_edge);
          check("sel_at_done", bus.sel, rec.sel);
          if (rec.chg_edge >= 0) check("sel_change_edge", last_chg, rec.chg_edge);
          check("gate_low_cycles", low_cnt, rec.low);
        end
        low_cnt = 0;
      end
      if (bus.gate_en !== 1'b1) low_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    bus.req_valid = 1'b0;
    bus.req_sel   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_free = edge_n;
    check("rst_sel", bus.sel, INIT);
    check("rst_gate_en", bus.gate_en, 1'b1);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // Same-select, then a full 0->1 switch, then back-to-back held requests.
    send(1'b0);
    idle(3);
    send(1'b1);
    idle(9);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    idle(10);

    // Abort a 0->1 switch with reset after its third edge.
    send(1'b0);
    idle(9);
    send(1'b1);
    repeat (4) @(posedge clk);
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_sel", bus.sel, INIT);
    check("abort_gate_en", bus.gate_en, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    sbq.delete();
    low_cnt   = 0;
    prev_sel  = INIT;
    model_sel = INIT;
    @(negedge clk);
    rst_n = 1'b1;
    model_free = edge_n;
    idle(8);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) send(1'($urandom_range(0, 1)));
      else drive_cycle(1'b0, 1'b0, acc);
    end
    idle(OFF + SET + 4);

`ifdef GMUX_SEL_CTRL_LOCK_EN
    begin
      logic keep;
      keep = model_sel;
      @(negedge clk);
      lock = 1'b1;
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, ~keep, acc);
      check("lock_sel_held", bus.sel, keep);
      lock = 1'b0;
      send(~keep);
      idle(OFF + SET + 4);
    end
`endif

    check("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
